// File: rtl/id_issue_if.sv
// id_issue_if: fetch-side handshake, flush, and decoded-bundle bus for id_issue.
//   Fetch in   : instr_i[31:0], pc_i[31:0], in_valid -> ; <- in_ready
//   Redirect   : flush
//   Bundle out : out_valid, pc_o, rs, rt, rd, opcode, func, address, immediate,
//                RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp,
//                Jump, illegal -> ; <- out_ready
//   Statistics : bubble_cnt, squash_cnt (CNT_W bits each)
// The master modport is the environment (fetch + ID/RR stage); the slave is id_issue.
interface id_issue_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_i;
  logic [31:0]      pc_i;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      pc_o;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic [25:0]      address;
  logic [15:0]      immediate;
  logic             RegDst;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       ALUOp;
  logic             Jump;
  logic             illegal;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output instr_i, pc_i, in_valid, flush, out_ready,
    input  in_ready, out_valid, pc_o, rs, rt, rd, opcode, func, address,
           immediate, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, Jump, illegal, bubble_cnt, squash_cnt
  );

  modport slave (
    input  instr_i, pc_i, in_valid, flush, out_ready,
    output in_ready, out_valid, pc_o, rs, rt, rd, opcode, func, address,
           immediate, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, Jump, illegal, bubble_cnt, squash_cnt
  );
endinterface

// File: rtl/id_issue.sv
// id_issue: instruction decode / issue stage.
//   Decodes a fetched MIPS-subset word into a registered bundle (1-cycle
//   latency), inserts one bubble on a load-use hazard against the held
//   bundle, optionally discards the word fetched after an accepted j, and
//   honours a later-stage flush.
// Ports:
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : id_issue_if.slave (fetch handshake, flush, bundle, counters)
// Parameters:
//   SQUASH_JUMP_SLOT : 1 = discard the word after an accepted j
//   CNT_W            : width of bubble_cnt / squash_cnt (saturating)
module id_issue #(
  parameter int unsigned SQUASH_JUMP_SLOT = 1,
  parameter int unsigned CNT_W            = 16
) (
  input logic       clk,
  input logic       rst,
  id_issue_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN,
    ST_SQUASH
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [25:0] address;
    logic [15:0] immediate;
    ctrl_t       ctrl;
    logic        illegal;
  } bundle_t;

  state_t           r_state;
  state_t           w_state_nxt;
  bundle_t          r_bundle;
  bundle_t          w_bundle_nxt;
  bundle_t          w_dec;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] w_bubble_cnt_nxt;
  logic [CNT_W-1:0] r_squash_cnt;
  logic [CNT_W-1:0] w_squash_cnt_nxt;
  logic             w_uses_rt;
  logic             w_free;
  logic             w_hazard;
  logic             w_accept;

  // Field split and control decode of the incoming word.
  always_comb begin
    w_dec           = '0;
    w_dec.pc        = bus.pc_i;
    w_dec.opcode    = bus.instr_i[31:26];
    w_dec.rs        = bus.instr_i[25:21];
    w_dec.rt        = bus.instr_i[20:16];
    w_dec.rd        = bus.instr_i[15:11];
    w_dec.func      = bus.instr_i[5:0];
    w_dec.immediate = bus.instr_i[15:0];
    w_dec.address   = bus.instr_i[25:0];
    w_uses_rt       = 1'b0;
    unique case (bus.instr_i[31:26])
      OP_RTYPE: begin
        w_dec.ctrl = 9'b1_0_0_1_0_0_10_0;
        w_uses_rt  = 1'b1;
      end
      OP_LW:   w_dec.ctrl = 9'b0_1_1_1_1_0_00_0;
      OP_SW: begin
        w_dec.ctrl = 9'b0_1_0_0_0_1_00_0;
        w_uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        w_dec.ctrl = 9'b0_0_0_0_0_0_01_0;
        w_uses_rt  = 1'b1;
      end
      OP_ADDI: w_dec.ctrl = 9'b0_1_0_1_0_0_00_0;
      OP_J:    w_dec.ctrl = 9'b0_0_0_0_0_0_00_1;
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // Output register may load when empty or being drained this cycle.
  assign w_free = !r_out_valid || bus.out_ready;

  // Load-use: the held bundle is a load whose destination is read by the
  // incoming word; $0 never creates a dependency.
  assign w_hazard = r_out_valid && r_bundle.ctrl.mem_read && (r_bundle.rt != 5'd0) &&
                    ((r_bundle.rt == w_dec.rs) || (w_uses_rt && (r_bundle.rt == w_dec.rt)));

  assign bus.in_ready = !rst && !bus.flush && w_free && !w_hazard;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Next-state / next-bundle. Reset is applied in the register process.
  always_comb begin
    w_state_nxt      = r_state;
    w_bundle_nxt     = r_bundle;
    w_out_valid_nxt  = r_out_valid;
    w_bubble_cnt_nxt = r_bubble_cnt;
    w_squash_cnt_nxt = r_squash_cnt;
    if (bus.flush) begin
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = ST_RUN;
    end else if (w_free) begin
      if (w_hazard) begin
        w_out_valid_nxt = 1'b0;
        if (r_bubble_cnt != '1) w_bubble_cnt_nxt = r_bubble_cnt + CNT_ONE;
      end else if (w_accept) begin
        if (r_state == ST_SQUASH) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_RUN;
          if (r_squash_cnt != '1) w_squash_cnt_nxt = r_squash_cnt + CNT_ONE;
        end else begin
          w_bundle_nxt    = w_dec;
          w_out_valid_nxt = 1'b1;
          if ((SQUASH_JUMP_SLOT != 0) && w_dec.ctrl.jump) w_state_nxt = ST_SQUASH;
        end
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_bundle     <= '0;
      r_out_valid  <= 1'b0;
      r_bubble_cnt <= '0;
      r_squash_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bundle     <= w_bundle_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_bubble_cnt <= w_bubble_cnt_nxt;
      r_squash_cnt <= w_squash_cnt_nxt;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.pc_o       = r_bundle.pc;
  assign bus.rs         = r_bundle.rs;
  assign bus.rt         = r_bundle.rt;
  assign bus.rd         = r_bundle.rd;
  assign bus.opcode     = r_bundle.opcode;
  assign bus.func       = r_bundle.func;
  assign bus.address    = r_bundle.address;
  assign bus.immediate  = r_bundle.immediate;
  assign bus.RegDst     = r_bundle.ctrl.reg_dst;
  assign bus.ALUSrc     = r_bundle.ctrl.alu_src;
  assign bus.MemtoReg   = r_bundle.ctrl.mem_to_reg;
  assign bus.RegWrite   = r_bundle.ctrl.reg_write;
  assign bus.MemRead    = r_bundle.ctrl.mem_read;
  assign bus.MemWrite   = r_bundle.ctrl.mem_write;
  assign bus.ALUOp      = r_bundle.ctrl.alu_op;
  assign bus.Jump       = r_bundle.ctrl.jump;
  assign bus.illegal    = r_bundle.illegal;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: scoreboard bench for id_issue. Stimulus pushes the expected
// bundle of every word that should issue; an independent monitor pops and
// compares on each bundle transfer (out_valid & out_ready).
module tb_id_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_issue_if #(.CNT_W(16)) bus ();

  id_issue #(.SQUASH_JUMP_SLOT(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [25:0] addr;
    logic [15:0] imm;
    logic [8:0]  ctrl;   // RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],Jump
    logic        ill;
    logic [3:0]  waits;  // cycles in_ready stays low before acceptance
    logic [7:0]  bub;    // bubble_cnt once accepted
  } vec_t;

  vec_t            vt[14];
  logic [110:0]    sb[$];
  int              total = 0;
  int              bad   = 0;

  function automatic logic [110:0] act_bundle();
    return {bus.pc_o, bus.rs, bus.rt, bus.rd, bus.opcode, bus.func, bus.address,
            bus.immediate, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
            bus.MemRead, bus.MemWrite, bus.ALUOp, bus.Jump, bus.illegal};
  endfunction

  function automatic logic [110:0] exp_of(input vec_t v, input logic [31:0] pc);
    return {pc, v.rs, v.rt, v.rd, v.op, v.func, v.addr, v.imm, v.ctrl, v.ill};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every transferred bundle must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_bundle: got %0h want none", act_bundle());
      end else begin
        logic [110:0] e;
        e = sb.pop_front();
        if (act_bundle() !== e) begin
          bad++;
          $display("FAIL bundle: got %0h want %0h", act_bundle(), e);
        end
      end
    end
  end

  // Present a word from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bit push,
                      input logic [110:0] exp, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.instr_i  = instr;
    bus.pc_i     = pc;
    bus.in_valid = 1'b1;
    if (push) sb.push_back(exp);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready want in_ready for %0h", instr);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.instr_i  = '0;
    bus.pc_i     = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int w;
    //          instr         rs     rt     rd     op     func   addr          imm        ctrl          ill waits bub
    vt[0]  = '{32'h20010005, 5'd0, 5'd1, 5'd0, 6'h08, 6'h05, 26'h0010005, 16'h0005, 9'b010100000, 1'b0, 4'd0, 8'd0}; // addi $1,$0,5
    vt[1]  = '{32'hACC50008, 5'd6, 5'd5, 5'd0, 6'h2B, 6'h08, 26'h0C50008, 16'h0008, 9'b010001000, 1'b0, 4'd0, 8'd0}; // sw $5,8($6)
    vt[2]  = '{32'h1022FFFF, 5'd1, 5'd2, 5'd31, 6'h04, 6'h3F, 26'h022FFFF, 16'hFFFF, 9'b000000010, 1'b0, 4'd0, 8'd0}; // beq $1,$2,-1
    vt[3]  = '{32'h8C220000, 5'd1, 5'd2, 5'd0, 6'h23, 6'h00, 26'h0220000, 16'h0000, 9'b011110000, 1'b0, 4'd0, 8'd0}; // lw $2,0($1)
    vt[4]  = '{32'h00441820, 5'd2, 5'd4, 5'd3, 6'h00, 6'h20, 26'h0441820, 16'h1820, 9'b100100100, 1'b0, 4'd1, 8'd1}; // add $3,$2,$4
    vt[5]  = '{32'h8C220000, 5'd1, 5'd2, 5'd0, 6'h23, 6'h00, 26'h0220000, 16'h0000, 9'b011110000, 1'b0, 4'd0, 8'd1}; // lw $2,0($1)
    vt[6]  = '{32'h21220001, 5'd9, 5'd2, 5'd0, 6'h08, 6'h01, 26'h1220001, 16'h0001, 9'b010100000, 1'b0, 4'd0, 8'd1}; // addi $2,$9,1
    vt[7]  = '{32'h8C220000, 5'd1, 5'd2, 5'd0, 6'h23, 6'h00, 26'h0220000, 16'h0000, 9'b011110000, 1'b0, 4'd0, 8'd1}; // lw $2,0($1)
    vt[8]  = '{32'hAC620000, 5'd3, 5'd2, 5'd0, 6'h2B, 6'h00, 26'h0620000, 16'h0000, 9'b010001000, 1'b0, 4'd1, 8'd2}; // sw $2,0($3)
    vt[9]  = '{32'h8C200000, 5'd1, 5'd0, 5'd0, 6'h23, 6'h00, 26'h0200000, 16'h0000, 9'b011110000, 1'b0, 4'd0, 8'd2}; // lw $0,0($1)
    vt[10] = '{32'h00041820, 5'd0, 5'd4, 5'd3, 6'h00, 6'h20, 26'h0041820, 16'h1820, 9'b100100100, 1'b0, 4'd0, 8'd2}; // add $3,$0,$4
    vt[11] = '{32'hFC000000, 5'd0, 5'd0, 5'd0, 6'h3F, 6'h00, 26'h0000000, 16'h0000, 9'b000000000, 1'b1, 4'd0, 8'd2}; // illegal
    vt[12] = '{32'h08000040, 5'd0, 5'd0, 5'd0, 6'h02, 6'h00, 26'h0000040, 16'h0040, 9'b000000001, 1'b0, 4'd0, 8'd0}; // j 0x40
    vt[13] = '{32'h00C72822, 5'd6, 5'd7, 5'd5, 6'h00, 6'h22, 26'h0C72822, 16'h2822, 9'b100100100, 1'b0, 4'd0, 8'd0}; // sub $5,$6,$7

    bus.instr_i   = '0;
    bus.pc_i      = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("in_ready_in_reset", 128'(bus.in_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_bundle", 128'(act_bundle()), 128'(0));
    chk("rst_bubble_cnt", 128'(bus.bubble_cnt), 128'(0));
    chk("rst_squash_cnt", 128'(bus.squash_cnt), 128'(0));
    @(posedge clk);
    #1;

    // Decode table, back-to-back, with load-use cases
    for (int i = 0; i < 12; i++) begin
      send(vt[i].instr, 32'h1000 + 32'(i * 4), 1'b1, exp_of(vt[i], 32'h1000 + 32'(i * 4)), w);
      chk($sformatf("waits_%0d", i), 128'(w), 128'(vt[i].waits));
      chk($sformatf("bubble_cnt_%0d", i), 128'(bus.bubble_cnt), 128'(vt[i].bub));
      if (i == 0) begin
        @(negedge clk);
        chk("addi_out_valid", 128'(bus.out_valid), 128'(1));
        @(posedge clk);
        #1;
      end
    end
    idle(2);

    // Jump slot squash
    pulse_reset();
    send(vt[12].instr, 32'h2000, 1'b1, exp_of(vt[12], 32'h2000), w);
    send(vt[13].instr, 32'h2004, 1'b0, '0, w);
    @(negedge clk);
    chk("squash_out_valid", 128'(bus.out_valid), 128'(0));
    chk("squash_cnt", 128'(bus.squash_cnt), 128'(1));
    @(posedge clk);
    #1;
    send(vt[0].instr, 32'h2008, 1'b1, exp_of(vt[0], 32'h2008), w);
    chk("after_squash_waits", 128'(w), 128'(0));
    idle(2);

    // Stall with a dependent word waiting, then flush
    bus.out_ready = 1'b0;
    send(vt[3].instr, 32'h3000, 1'b0, '0, w);
    bus.instr_i  = vt[4].instr;
    bus.pc_i     = 32'h3004;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", c), 128'(bus.out_valid), 128'(1));
      chk($sformatf("stall_bundle_%0d", c), 128'(act_bundle()), 128'(exp_of(vt[3], 32'h3000)));
      chk($sformatf("stall_in_ready_%0d", c), 128'(bus.in_ready), 128'(0));
    end
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("stall_bubble_cnt", 128'(bus.bubble_cnt), 128'(0));
    chk("flush_squash_cnt", 128'(bus.squash_cnt), 128'(1));
    @(posedge clk);
    #1;

    // Reset while in SQUASH drops the pending squash
    send(vt[12].instr, 32'h4000, 1'b1, exp_of(vt[12], 32'h4000), w);
    idle(1);
    pulse_reset();
    send(vt[0].instr, 32'h4004, 1'b1, exp_of(vt[0], 32'h4004), w);
    @(negedge clk);
    chk("rst_squash_issue", 128'(bus.out_valid), 128'(1));
    chk("rst_squash_cnt", 128'(bus.squash_cnt), 128'(0));
    @(posedge clk);
    #1;
    idle(1);

    // Illegal word then reset
    send(vt[11].instr, 32'h5000, 1'b1, exp_of(vt[11], 32'h5000), w);
    rst = 1'b1;
    @(negedge clk);
    chk("illegal_out_valid", 128'(bus.out_valid), 128'(1));
    chk("illegal_flag", 128'(bus.illegal), 128'(1));
    chk("in_ready_rst", 128'(bus.in_ready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst2_bundle", 128'(act_bundle()), 128'(0));
    idle(3);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 Parameter: SQUASH_JUMP_SLOT, default 1, when 1 the instruction fetched after an accepted j is discarded.
REQ-002 Parameter: CNT_W, default 16, width of the bubble and squash counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr_i  in  32  fetched instruction word; pc_i  in  32  its PC.
REQ-006 in_valid  in  1  fetch word valid; in_ready  out  1  block accepts word this cycle.
REQ-007 flush  in  1  later-stage redirect; kills held and incoming instruction.
REQ-008 out_valid  out  1  decoded bundle valid; out_ready  in  1  ID/RR register accepts bundle.
REQ-009 Bundle outputs (registered): pc_o 32, rs 5, rt 5, rd 5, opcode 6, func 6, address 26, immediate 16, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite 1 each, ALUOp 2, Jump 1, illegal 1.
REQ-010 bubble_cnt  out  CNT_W  load-use bubbles inserted; squash_cnt  out  CNT_W  jump slots discarded.

Function
REQ-011 Field split SHALL be: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0], immediate=[15:0], address=[25:0].
REQ-012 Decode SHALL be, as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Jump}: R-type 000000 -> 1,0,0,1,0,0,10,0; lw 100011 -> 0,1,1,1,1,0,00,0; sw 101011 -> 0,1,0,0,0,1,00,0; beq 000100 -> 0,0,0,0,0,0,01,0; addi 001000 -> 0,1,0,1,0,0,00,0; j 000010 -> 0,0,0,0,0,0,00,1.
REQ-013 Any other opcode SHALL decode to all control bits 0 with illegal=1; it is still issued.
REQ-014 Output register SHALL load when out_valid=0 or out_ready=1 (free); otherwise hold all bundle outputs unchanged.
REQ-015 hazard SHALL be: out_valid & MemRead(held) & rt(held)!=0 & (rt(held)==rs(in) | (in uses rt & rt(held)==rt(in))); R-type, sw, beq use rt.
REQ-016 in_ready SHALL be: !rst & !flush & free & !hazard.
REQ-017 Accept (in_valid & in_ready) in state RUN SHALL load decoded bundle, out_valid=1 next cycle; latency instr_i to bundle = 1 cycle.
REQ-018 hazard with free SHALL load out_valid=0 (one bubble) and increment bubble_cnt; next cycle hazard is clear and the word is accepted.
REQ-019 States RUN, SQUASH. RUN -> SQUASH on accepting j when SQUASH_JUMP_SLOT=1; SQUASH -> RUN on next accept.
REQ-020 Accept in SQUASH SHALL discard the word, load out_valid=0, increment squash_cnt.
REQ-021 free with no accept and no hazard SHALL load out_valid=0.
REQ-022 flush SHALL have priority: next cycle out_valid=0, state=RUN, no word accepted, counters unchanged.
REQ-023 Counters SHALL saturate at all ones.
REQ-024 Stalled bundle (out_valid=1, out_ready=0) SHALL stay stable; hazard not counted while stalled.

Reset
REQ-025 rst=1 SHALL next cycle give out_valid=0, state=RUN, bubble_cnt=0, squash_cnt=0, all bundle outputs 0, in_ready=0 during reset.
REQ-026 rst mid-stall or in SQUASH SHALL discard held bundle and pending squash; rst overrides flush.

Verification
REQ-027 addi $1,$0,5 (0x20010005) in, out_ready=1 -> next cycle out_valid=1, rs=0, rt=1, immediate=0x0005, ALUSrc=1, RegWrite=1, ALUOp=00.
REQ-028 lw $2,0($1) then add $3,$2,$4 back-to-back -> one out_valid=0 cycle between them, in_ready=0 that cycle, bubble_cnt=1.
REQ-029 lw $0,0($1) then add $3,$0,$4 -> no bubble, bubble_cnt=0.
REQ-030 j 0x0000040 then sub word -> j issued with Jump=1, address=0x40; sub discarded, squash_cnt=1; following word issued.
REQ-031 out_ready=0 for 3 cycles with valid bundle -> outputs stable, in_ready=0; flush asserted -> next cycle out_valid=0.
REQ-032 opcode 111111 -> illegal=1, all controls 0, out_valid=1; rst asserted next -> all outputs 0.
